// File: rtl/psdsqrt_pkg.sv
// Shared definitions for the square-root sequencer: FSM states, default
// widths and a reference integer square root usable by RTL and benches.
package psdsqrt_pkg;

    localparam int NITER_DEF = 16;
    localparam int XW_DEF    = 32;
    localparam int RW_DEF    = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        RUN     = 3'd2,
        STOP    = 3'd3,
        CAPTURE = 3'd4,
        HOLD    = 3'd5
    } state_e;

    // Digit-by-digit floor(sqrt(x)) for a 32-bit operand.
    function automatic logic [15:0] ref_sqrt(input logic [31:0] x);
        logic [31:0] op;
        logic [31:0] res;
        logic [31:0] one;
        op  = x;
        res = '0;
        one = 32'h4000_0000;
        for (int i = 0; i < 16; i++) begin
            if (op >= res + one) begin
                op  = op - (res + one);
                res = (res >> 1) + one;
            end else begin
                res = res >> 1;
            end
            one = one >> 2;
        end
        return res[15:0];
    endfunction

endpackage

// File: rtl/psdsqrt_ctrl_if.sv
// Request/response valid-ready bundle between system logic and the
// square-root sequencer; slave is the controller side.
interface psdsqrt_ctrl_if #(
    parameter int XW = 32,
    parameter int RW = 16
) ();
    logic          req_valid;
    logic          req_ready;
    logic [XW-1:0] req_x;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [RW-1:0] rsp_sqrt;
    logic [XW-1:0] rsp_x;

    modport slave (
        input  req_valid, req_x, rsp_ready,
        output req_ready, rsp_valid, rsp_sqrt, rsp_x
    );

    modport master (
        output req_valid, req_x, rsp_ready,
        input  req_ready, rsp_valid, rsp_sqrt, rsp_x
    );
endinterface

// File: rtl/psdsqrt_ctrl.sv
// Sequencer for the iterative square-root core: accepts one operand, pulses
// start/stop NITER+1 cycles apart, captures the root and holds it for the consumer.
module psdsqrt_ctrl
    import psdsqrt_pkg::*;
#(
    parameter int NITER = NITER_DEF,
    parameter int XW    = XW_DEF,
    parameter int RW    = RW_DEF
) (
    input  logic          clock,
    input  logic          reset,
    psdsqrt_ctrl_if.slave bus,
    output logic          core_start,
    output logic          core_stop,
    output logic [XW-1:0] core_xin,
    input  logic [RW-1:0] core_sqrt,
    output logic [15:0]   ops_done
);

    localparam int            CW       = (NITER > 1) ? $clog2(NITER) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(NITER - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [XW-1:0] x_q;
    logic [RW-1:0] sqrt_q;
    logic [15:0]   ops_q;
    logic          idle_ready;
    logic          hold_valid;
    logic          req_fire;
    logic          rsp_fire;

    assign req_fire = (state_q == IDLE) && bus.req_valid;
    assign rsp_fire = (state_q == HOLD) && bus.rsp_ready;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        core_start = 1'b0;
        core_stop  = 1'b0;
        idle_ready = 1'b0;
        hold_valid = 1'b0;
        case (state_q)
            IDLE: begin
                idle_ready = 1'b1;
                if (bus.req_valid) state_d = START;
            end
            START: begin
                core_start = 1'b1;
                cnt_d      = CNT_LOAD;
                state_d    = RUN;
            end
            RUN: begin
                // Counter reaches zero on the NITER-th RUN cycle.
                if (cnt_q == '0) state_d = STOP;
                else             cnt_d   = cnt_q - CW'(1);
            end
            STOP: begin
                core_stop = 1'b1;
                state_d   = CAPTURE;
            end
            CAPTURE: state_d = HOLD;
            HOLD: begin
                hold_valid = 1'b1;
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state and datapath registers use non-blocking assignments and
    // share one synchronous reset; the operand register doubles as rsp_x.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            sqrt_q  <= '0;
            ops_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (req_fire)            x_q    <= bus.req_x;
            if (state_q == CAPTURE)  sqrt_q <= core_sqrt;
            if (rsp_fire)            ops_q  <= ops_q + 16'd1;
        end
    end

    // Ready is masked during reset so a request raised under reset is never seen.
    assign bus.req_ready = idle_ready & ~reset;
    assign bus.rsp_valid = hold_valid;
    assign bus.rsp_sqrt  = sqrt_q;
    assign bus.rsp_x     = x_q;
    assign core_xin      = x_q;
    assign ops_done      = ops_q;

endmodule
